div_share_arb: RTL and testbench
================================

// Module: div_share_arb
// PURPOSE
//  Shares one sequential 16-bit restoring divider between NUM_REQ requesters.
//  Round-robin arbitration, valid/ready handshakes, one operation in flight.
//  Sits between client blocks and the div_seq_core sub-module; returns quotient/remainder tagged with requester ID.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DW       16  dividend/quotient width; divisor/remainder width is DW+1
//  IDW      2   requester ID width, $clog2(NUM_REQ)
// PORTS
//  clk         in   1             clock, all logic on rising edge
//  rst         in   1             synchronous, active-high reset
//  req_valid   in   NUM_REQ       per-requester request valid
//  req_ready   out  NUM_REQ       per-requester accept, one-hot or zero
//  req_dvd     in   NUM_REQ*DW    packed dividends, requester i at [i*DW +: DW]
//  req_dvs     in   NUM_REQ*(DW+1) packed divisors, requester i at [i*(DW+1) +: DW+1]
//  resp_valid  out  1             result valid
//  resp_ready  in   1             result consumed
//  resp_id     out  IDW           index of requester owning the result
//  resp_quot   out  DW            quotient
//  resp_rem    out  DW+1          remainder
//  busy        out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id/quot/rem=0, busy=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: req_ready is combinational. One-hot grant to the first valid requester, searching from rr_ptr upward with wrap.
//         On handshake: latch operands and ID; rr_ptr = grant+1 (mod NUM_REQ); go to RUN with cnt=DW.
//   RUN:  one restoring step per cycle. {A,Q} shifts left. T = A - D (DW+2 bits).
//         If T >= 0: A = T and Q[0] = 1. Otherwise A is unchanged and Q[0] = 0.
//         cnt decrements; at cnt == 1 the step completes and the FSM goes to DONE.
//   DONE: resp_valid=1, outputs stable until resp_ready. On resp_valid & resp_ready go to IDLE.
//  Latency: accept in cycle 0, resp_valid first high in cycle DW+1 (17 by default).
//  Throughput: one op per DW+2 cycles if resp_ready is held high.
//  req_ready=0 in RUN and DONE. No grant can occur in the same cycle as a response handshake.
//  A requester that drops req_valid before its grant is skipped and loses no state.
//  Divisor 0: result is quot = all-ones, rem = dividend (natural result of the algorithm).
//  Divisor >= 2^DW: result is quot = 0, rem = dividend.
//  Reset mid-RUN or mid-DONE: the operation is discarded with no response; all registers take their reset values.
//  All NUM_REQ valid continuously: grants follow strict rotation 0,1,2,3,0,...
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined:
//   - adds output port resp_dz (1 bit, reset 0).
//   - an accepted divisor of 0 goes IDLE -> DONE directly. resp_valid is high in cycle 1.
//   - result is quot = all-ones, rem = dividend, resp_dz = 1. resp_dz = 0 for every other result.
//  Not defined: no resp_dz port; divide-by-zero takes the full DW+1 cycle path with the same quot/rem.
// STRUCTURE
//  Package div_pkg:
//   - DW_DEF=16, state enum {IDLE,RUN,DONE}.
//   - function rr_pick(valid, ptr) returning a one-hot grant.
//  Sub-module div_seq_core:
//   - ports start, dvd, dvs, done, quot, rem. Holds A/Q/D/cnt.
//   - div_share_arb holds the FSM, arbitration, ID and response registers.
// TESTING
//  1 Req0 100/7, resp_ready=1 -> resp_valid in cycle 17, quot=14, rem=2, id=0.
//  2 Req2 65535/1 -> quot=65535, rem=0. Req1 5/9 -> quot=0, rem=5. Req3 1234/65536 -> quot=0, rem=1234.
//  3 All four valid from reset, each with operands i+10 / 3 -> ids 0,1,2,3,0 in order.
//    Each pair is correct; no req_ready while busy.
//  4 resp_ready held low 10 cycles in DONE -> outputs stable, req_ready all 0.
//    Release -> IDLE, next grant the following cycle.
//  5 1234/0 -> quot=0xFFFF, rem=1234. With DIV_ZERO_FAST_EN: resp_valid in cycle 1, resp_dz=1.
//  6 rst asserted at RUN cycle 8 -> no resp_valid afterwards.
//    Outputs 0 and rr_ptr=0; next request from req1 is served correctly.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, defaults and round-robin pick for the shared divider
package div_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot grant to the first set bit of valid at or above ptr, wrapping within n slots.
    function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                           input int unsigned n);
        logic [7:0]  g;
        logic        found;
        int unsigned idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && !found && valid[idx[2:0]]) begin
                g[idx[2:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/div_seq_core.sv
// rtl/div_seq_core.sv - sequential restoring divider, one quotient bit per cycle
module div_seq_core #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dvd,
    input  logic [DW:0]   dvs,
    output logic          done,
    output logic [DW-1:0] quot,
    output logic [DW:0]   rem
);
    localparam int CW = $clog2(DW + 1);

    logic [DW:0]   a_q, a_d, d_q, d_d;
    logic [DW-1:0] q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW+1:0] shifted, trial;
    logic [DW:0]   step_a;
    logic [DW-1:0] step_q;

    always_comb begin
        shifted = {a_q, q_q[DW-1]};
        trial   = shifted - {1'b0, d_q};
        // A stays below D, so the shifted partial remainder always fits back in DW+1 bits.
        step_a  = trial[DW+1] ? shifted[DW:0] : trial[DW:0];
        step_q  = {q_q[DW-2:0], ~trial[DW+1]};

        a_d   = a_q;
        q_d   = q_q;
        d_d   = d_q;
        cnt_d = cnt_q;
        if (start) begin
            a_d   = '0;
            q_d   = dvd;
            d_d   = dvs;
            cnt_d = CW'(DW);
        end else if (cnt_q != '0) begin
            a_d   = step_a;
            q_d   = step_q;
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign done = (cnt_q == CW'(1));
    assign quot = step_q;
    assign rem  = step_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_share_arb.sv
// rtl/div_share_arb.sv - round-robin sharing of one divider core; DIV_ZERO_FAST_EN adds a divide-by-zero shortcut and resp_dz
module div_share_arb
    import div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = DW_DEF,
    parameter int IDW     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*DW-1:0]   req_dvd,
    input  logic [NUM_REQ*(DW+1)-1:0] req_dvs,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [DW-1:0]           resp_quot,
    output logic [DW:0]             resp_rem,
    output logic                    busy
`ifdef DIV_ZERO_FAST_EN
    ,
    output logic                    resp_dz
`endif
);
    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, resp_id_q, resp_id_d, gidx;
    logic [DW-1:0]  resp_quot_q, resp_quot_d, sel_dvd, core_quot;
    logic [DW:0]    resp_rem_q, resp_rem_d, sel_dvs, core_rem;
    logic [7:0]     pick;
    logic [NUM_REQ-1:0] grant;
    logic           hs, fast_dz, core_start, core_done;
`ifdef DIV_ZERO_FAST_EN
    logic           resp_dz_q, resp_dz_d;
`endif

    always_comb begin
        pick    = rr_pick(8'(req_valid), 3'(rr_ptr_q), NUM_REQ);
        grant   = pick[NUM_REQ-1:0];
        gidx    = '0;
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx    = IDW'(i);
                sel_dvd = req_dvd[i*DW +: DW];
                sel_dvs = req_dvs[i*(DW+1) +: DW+1];
            end
        end
        hs = (state_q == IDLE) && (|pick);
`ifdef DIV_ZERO_FAST_EN
        fast_dz = hs && (sel_dvs == '0);
`else
        fast_dz = 1'b0;
`endif
        core_start = hs && !fast_dz;
    end

    div_seq_core #(.DW(DW)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .dvd   (sel_dvd),
        .dvs   (sel_dvs),
        .done  (core_done),
        .quot  (core_quot),
        .rem   (core_rem)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = fast_dz ? DONE : RUN;
            RUN:     if (core_done) state_d = DONE;
            DONE:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state_q == DONE);
        busy       = (state_q != IDLE);
        req_ready  = (state_q == IDLE) ? grant : '0;
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        resp_quot_d = resp_quot_q;
        resp_rem_d  = resp_rem_q;
`ifdef DIV_ZERO_FAST_EN
        resp_dz_d   = resp_dz_q;
`endif
        if (hs) begin
            rr_ptr_d  = (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + IDW'(1);
            resp_id_d = gidx;
`ifdef DIV_ZERO_FAST_EN
            resp_dz_d = fast_dz;
`endif
            if (fast_dz) begin
                resp_quot_d = '1;
                resp_rem_d  = {1'b0, sel_dvd};
            end
        end
        // Capture the final step's result as the core produces it, so DONE shows it immediately.
        if (state_q == RUN && core_done) begin
            resp_quot_d = core_quot;
            resp_rem_d  = core_rem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            resp_id_q   <= '0;
            resp_quot_q <= '0;
            resp_rem_q  <= '0;
`ifdef DIV_ZERO_FAST_EN
            resp_dz_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            resp_quot_q <= resp_quot_d;
            resp_rem_q  <= resp_rem_d;
`ifdef DIV_ZERO_FAST_EN
            resp_dz_q   <= resp_dz_d;
`endif
        end
    end

    assign resp_id   = resp_id_q;
    assign resp_quot = resp_quot_q;
    assign resp_rem  = resp_rem_q;
`ifdef DIV_ZERO_FAST_EN
    assign resp_dz   = resp_dz_q;
`endif

endmodule

// File: tb/tb_div_share_arb.sv
// tb/tb_div_share_arb.sv - directed self-checking bench for div_share_arb (either DIV_ZERO_FAST_EN build)
module tb_div_share_arb;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int IDW = 2;
`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 17;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid, req_ready;
    logic [N*DW-1:0]      req_dvd;
    logic [N*(DW+1)-1:0]  req_dvs;
    logic                 resp_valid, resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [DW-1:0]        resp_quot;
    logic [DW:0]          resp_rem;
    logic                 busy;
`ifdef DIV_ZERO_FAST_EN
    logic                 resp_dz;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_share_arb #(.NUM_REQ(N), .DW(DW), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dvd    (req_dvd),
        .req_dvs    (req_dvs),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_quot  (resp_quot),
        .resp_rem   (resp_rem),
        .busy       (busy)
`ifdef DIV_ZERO_FAST_EN
        ,
        .resp_dz    (resp_dz)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int id, input logic [15:0] dvd, input logic [16:0] dvs);
        req_dvd[id*DW +: DW]         = dvd;
        req_dvs[id*(DW+1) +: (DW+1)] = dvs;
    endtask

    // Called on the first negedge after the accepting edge; returns the cycle index of resp_valid.
    task automatic wait_resp(output int n);
        n = 1;
        while (resp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input int id, input logic [15:0] dvd, input logic [16:0] dvs,
                          input logic [15:0] eq, input logic [16:0] er, input int elat,
                          input string tag);
        int n;
        @(negedge clk);
        set_op(id, dvd, dvs);
        req_valid = 4'(1 << id);
        #1;
        check($sformatf("%s_rdy", tag), 64'(req_ready), 64'(1 << id));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(n);
        check($sformatf("%s_lat", tag), 64'(n), 64'(elat));
        check($sformatf("%s_id", tag), 64'(resp_id), 64'(id));
        check($sformatf("%s_quot", tag), 64'(resp_quot), 64'(eq));
        check($sformatf("%s_rem", tag), 64'(resp_rem), 64'(er));
`ifdef DIV_ZERO_FAST_EN
        check($sformatf("%s_dz", tag), 64'(resp_dz), 64'(dvs == 17'd0));
`endif
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] rot_q [4];
        logic [16:0] rot_r [4];
        rot_q = '{16'd3, 16'd3, 16'd4, 16'd4};
        rot_r = '{17'd1, 17'd2, 17'd0, 17'd1};

        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        req_dvd    = '0;
        req_dvs    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out", 64'({resp_valid, resp_id, resp_quot, resp_rem, busy, req_ready}), 64'd0);

        // All four requesters valid from reset: strict rotation 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_op(i, 16'(i + 10), 17'd3);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rot%0d_rdy", k), 64'(req_ready), 64'(1 << (k % 4)));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rot%0d_run_rdy", k), 64'({busy, req_ready}), 64'h10);
            wait_resp(n);
            check($sformatf("rot%0d_lat", k), 64'(n), 64'd17);
            check($sformatf("rot%0d_id", k), 64'(resp_id), 64'(k % 4));
            check($sformatf("rot%0d_quot", k), 64'(resp_quot), 64'(rot_q[k % 4]));
            check($sformatf("rot%0d_rem", k), 64'(resp_rem), 64'(rot_r[k % 4]));
            check($sformatf("rot%0d_done_rdy", k), 64'(req_ready), 64'd0);
            if (k == 4) req_valid = '0;
            @(negedge clk);
        end

        run_op(0, 16'd100, 17'd7, 16'd14, 17'd2, 17, "t1");
        run_op(2, 16'd65535, 17'd1, 16'd65535, 17'd0, 17, "t2a");
        run_op(1, 16'd5, 17'd9, 16'd0, 17'd5, 17, "t2b");
        run_op(3, 16'd1234, 17'h10000, 16'd0, 17'd1234, 17, "t2c");

        // Back-pressure in DONE with another requester waiting.
        @(negedge clk);
        resp_ready = 1'b0;
        set_op(1, 16'd20, 17'd6);
        set_op(2, 16'd50, 17'd7);
        req_valid = 4'b0010;
        #1;
        check("bp_rdy", 64'(req_ready), 64'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0110;
        wait_resp(n);
        check("bp_lat", 64'(n), 64'd17);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i),
                  64'({resp_valid, resp_id, resp_quot, resp_rem, req_ready}),
                  64'({1'b1, 2'd1, 16'd3, 17'd2, 4'b0000}));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'({resp_valid, req_ready}), 64'h04);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(n);
        check("bp_next_lat", 64'(n), 64'd17);
        check("bp_next_res", 64'({resp_id, resp_quot, resp_rem}), 64'({2'd2, 16'd7, 17'd1}));

        run_op(0, 16'd1234, 17'd0, 16'hFFFF, 17'd1234, DZ_LAT, "dz");

        // Reset during RUN discards the operation and clears the pointer.
        @(negedge clk);
        set_op(0, 16'd1000, 17'd3);
        req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        n = 1;
        while (n < 8) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_out", 64'({resp_valid, resp_id, resp_quot, resp_rem, busy}), 64'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen = 1;
        end
        check("mid_rst_no_resp", 64'(seen), 64'd0);
        for (int i = 0; i < N; i++) set_op(i, 16'd300, 17'd7);
        req_valid = '1;
        #1;
        check("mid_rst_ptr", 64'(req_ready), 64'h1);
        req_valid = '0;
        run_op(1, 16'd300, 17'd7, 16'd42, 17'd6, 17, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
